// File: rtl/spn_cu_host.sv
// Host-side controller for an SPN cipher unit: accepts one request, drives the
// SPN for a single issue cycle, waits for its status (bounded) and returns a response.
module spn_cu_host #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_key,
    input  logic [15:0] req_data,
    output logic [1:0]  spn_opcode,
    output logic [31:0] spn_key,
    output logic [15:0] spn_data_in,
    input  logic [1:0]  spn_valid,
    input  logic [15:0] spn_data_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic [15:0] op_count,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ENC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [1:0] SV_NONE = 2'b00;
    localparam logic [1:0] SV_ENC  = 2'b01;
    localparam logic [1:0] SV_DEC  = 2'b10;
    localparam logic [1:0] SV_ERR  = 2'b11;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_MISMATCH = 2'b01;
    localparam logic [1:0] ST_UNDEF    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  tmo_cnt;
    logic [1:0]  op_q;
    logic        accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [1:0] capture_status(input logic [1:0] op, input logic [1:0] sv);
        if ((op == OP_ENC && sv == SV_ENC) || (op == OP_DEC && sv == SV_DEC))
            return ST_OK;
        else if (op == OP_UND && sv == SV_ERR)
            return ST_UNDEF;
        else
            return ST_MISMATCH;
    endfunction

    assign accept = req_valid && req_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = (req_op == OP_NOP) ? RESP : ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (spn_valid != SV_NONE || tmo_cnt == TMO_LAST) state_nx = RESP;
            RESP:  if (rsp_ready) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            spn_opcode  <= 2'b00;
            spn_key     <= 32'd0;
            spn_data_in <= 16'd0;
            op_q        <= 2'b00;
            tmo_cnt     <= 8'd0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 16'd0;
            rsp_status  <= ST_OK;
            op_count    <= 16'd0;
            err_count   <= 16'd0;
        end else begin
            state     <= state_nx;
            // ready is registered, so it cannot rise in the same cycle as the response handshake
            req_ready <= (state_nx == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        spn_opcode  <= req_op;
                        spn_key     <= req_key;
                        spn_data_in <= req_data;
                        op_q        <= req_op;
                        if (req_op == OP_NOP) begin
                            rsp_valid  <= 1'b1;
                            rsp_data   <= 16'd0;
                            rsp_status <= ST_OK;
                        end
                    end
                end
                ISSUE: begin
                    spn_opcode <= 2'b00;
                    tmo_cnt    <= 8'd0;
                end
                WAIT: begin
                    if (spn_valid != SV_NONE) begin
                        rsp_valid  <= 1'b1;
                        rsp_data   <= spn_data_out;
                        rsp_status <= capture_status(op_q, spn_valid);
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_valid  <= 1'b1;
                        rsp_data   <= 16'd0;
                        rsp_status <= ST_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= sat_inc(op_count);
                        if (rsp_status != ST_OK)
                            err_count <= sat_inc(err_count);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spn_cu_host.sv
// Bench for spn_cu_host: directed and randomized transactions against a
// transaction-level model of the expected response, latency and counters.
module tb_spn_cu_host;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_key = 32'd0;
    logic [15:0] req_data = 16'd0;
    logic [1:0]  spn_opcode;
    logic [31:0] spn_key;
    logic [15:0] spn_data_in;
    logic [1:0]  spn_valid = 2'b00;
    logic [15:0] spn_data_out = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_status;
    logic [15:0] op_count;
    logic [15:0] err_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ops = 0;
    int exp_errs = 0;

    spn_cu_host #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_data(req_data),
        .spn_opcode(spn_opcode), .spn_key(spn_key), .spn_data_in(spn_data_in),
        .spn_valid(spn_valid), .spn_data_out(spn_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .op_count(op_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response status as the SPN answer table defines it.
    function automatic logic [1:0] ref_status(input logic [1:0] op, input logic [1:0] code);
        if (op == 2'd1 && code == 2'd1) return 2'd0;
        if (op == 2'd2 && code == 2'd2) return 2'd0;
        if (op == 2'd3 && code == 2'd3) return 2'd2;
        return 2'd1;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_spn_opcode"}, spn_opcode, 0);
        chk({tag, "_spn_key"}, spn_key, 0);
        chk({tag, "_spn_data_in"}, spn_data_in, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_status"}, rsp_status, 0);
        chk({tag, "_op_count"}, op_count, 0);
        chk({tag, "_err_count"}, err_count, 0);
    endtask

    // One full transaction; d = WAIT cycle index at which the SPN answers (d >= T: never).
    task automatic run_txn(input logic [1:0] op, input logic [31:0] key, input logic [15:0] data,
                           input int d, input logic [1:0] code, input logic [15:0] rdata,
                           input int hold);
        logic [1:0]  exp_st;
        logic [15:0] exp_d;
        int          exp_wait;
        int          n;
        if (op == 2'd0) begin
            exp_st = 2'd0; exp_d = 16'd0; exp_wait = 0;
        end else if (d < T) begin
            exp_st = ref_status(op, code); exp_d = rdata; exp_wait = d + 1;
        end else begin
            exp_st = 2'd3; exp_d = 16'd0; exp_wait = T;
        end

        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_key = key; req_data = data;
        spn_valid = 2'($urandom); spn_data_out = 16'($urandom);
        @(negedge clk);
        req_valid = 1'b0; req_op = 2'($urandom);
        chk("req_ready_busy", req_ready, 0);
        chk("spn_key_latch", spn_key, key);
        chk("spn_data_latch", spn_data_in, data);
        if (op != 2'd0) begin
            chk("spn_opcode_issue", spn_opcode, op);
            chk("rsp_valid_issue", rsp_valid, 0);
            spn_valid = 2'($urandom);
            @(negedge clk);
            chk("spn_opcode_wait", spn_opcode, 0);
            chk("spn_key_hold", spn_key, key);
            chk("spn_data_hold", spn_data_in, data);
            chk("rsp_valid_wait", rsp_valid, 0);
            n = 0;
            while (!rsp_valid && n < T + 2) begin
                if (n == d) begin
                    spn_valid = code; spn_data_out = rdata;
                end else begin
                    spn_valid = 2'b00; spn_data_out = 16'($urandom);
                end
                @(negedge clk);
                n++;
            end
            chk("wait_cycles", n, exp_wait);
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_status", rsp_status, exp_st);
        chk("op_count_pre", op_count, exp_ops);
        chk("err_count_pre", err_count, exp_errs);
        spn_valid = 2'($urandom); spn_data_out = 16'($urandom);
        repeat (hold) begin
            @(negedge clk);
            spn_valid = 2'($urandom);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_data", rsp_data, exp_d);
            chk("hold_rsp_status", rsp_status, exp_st);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_op_count", op_count, exp_ops);
            chk("hold_err_count", err_count, exp_errs);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; spn_valid = 2'b00;
        exp_ops++;
        if (exp_st != 2'd0) exp_errs++;
        chk("rsp_valid_done", rsp_valid, 0);
        chk("req_ready_after", req_ready, 1);
        chk("op_count", op_count, exp_ops);
        chk("err_count", err_count, exp_errs);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset_async");
        @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_first_edge", req_ready, 1);

        run_txn(2'd1, 32'h3A94D63F, 16'h1234, 0, 2'd1, 16'hABCD, 0);
        run_txn(2'd2, 32'h0BADF00D, 16'h5555, 0, 2'd1, 16'h7777, 0);
        run_txn(2'd3, 32'h12345678, 16'h0F0F, 0, 2'd3, 16'h4242, 0);
        run_txn(2'd1, 32'hCAFEBABE, 16'h9999, T, 2'd1, 16'h1111, 0);
        run_txn(2'd0, 32'h11112222, 16'h3333, 0, 2'd0, 16'h0000, 0);
        run_txn(2'd2, 32'hDEADBEEF, 16'hA5A5, 2, 2'd2, 16'h5A5A, 10);
        run_txn(2'd1, 32'h00000001, 16'hFFFF, T - 1, 2'd1, 16'hFFFF, 0);

        // Reset while the controller is waiting on the SPN.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_key = 32'h55AA55AA; req_data = 16'h2468;
        @(negedge clk);
        req_valid = 1'b0; spn_valid = 2'b00;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_wait");
        @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 0; exp_errs = 0;
        @(negedge clk);
        chk("req_ready_after_abort", req_ready, 1);
        chk("rsp_valid_after_abort", rsp_valid, 0);
        chk("op_count_after_abort", op_count, 0);
        run_txn(2'd1, 32'h3A94D63F, 16'h1234, 0, 2'd1, 16'hABCD, 0);

        for (int i = 0; i < 40; i++) begin
            run_txn(2'($urandom), $urandom, 16'($urandom), int'($urandom_range(0, T + 1)),
                    2'($urandom_range(1, 3)), 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
